// File: rtl/reg_read_control.sv
// ---------------------------------------------------------------------------
// reg_read_control
//
// Read-side operand fetch for the MIPS single-cycle datapath. It picks the rs
// and rt operands out of the flattened 32-entry register file and snapshots
// them into output registers. It then presents them to the ALU operand stage
// through a valid/ready handshake.
//
// Optional feature (compile-time macro WR_BYPASS_EN):
//   defined   - a register-file write that targets a requested register in the
//               accept cycle is forwarded (operand = wr_data). bypass_cnt counts
//               the forwarded operands and saturates at 16'hFFFF.
//   undefined - operands always come from regs_flat. No forwarding comparators
//               are built, and bypass_cnt is tied to 0.
//
// Ports:
//   clk         in   rising-edge clock
//   rst_n       in   asynchronous active-low reset
//   regs_flat   in   register file contents, reg k at [k*DATA_W +: DATA_W]
//   rd_req      in   read request
//   rs_addr     in   first operand address
//   rt_addr     in   second operand address
//   rd_ready    in   consumer accepts the presented operands
//   we          in   register-file write enable
//   wr_addr     in   register-file write address
//   wr_data     in   register-file write data
//   rd_accept   out  combinational: request accepted this cycle
//   rd_valid    out  rs_data/rt_data valid
//   rs_data     out  registered rs operand
//   rt_data     out  registered rt operand
//   bypass_cnt  out  saturating count of forwarded operands
// ---------------------------------------------------------------------------
module reg_read_control #(
    parameter int DATA_W = 32,
    parameter int NREGS  = 32,
    localparam int ADDR_W = $clog2(NREGS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NREGS*DATA_W-1:0]   regs_flat,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rs_addr,
    input  logic [ADDR_W-1:0]         rt_addr,
    input  logic                      rd_ready,
    input  logic                      we,
    input  logic [ADDR_W-1:0]         wr_addr,
    input  logic [DATA_W-1:0]         wr_data,
    output logic                      rd_accept,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rs_data,
    output logic [DATA_W-1:0]         rt_data,
    output logic [15:0]               bypass_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic              valid_reg, valid_next;
    logic [DATA_W-1:0] rs_data_reg, rt_data_reg;

    // Unpacked view of the register file for address-indexed selection.
    logic [DATA_W-1:0] regs_arr [NREGS];

    // Port 0 = rs, port 1 = rt.
    logic [ADDR_W-1:0] port_addr [2];
    logic [DATA_W-1:0] operand   [2];
    logic [1:0]        fwd;

    assign port_addr[0] = rs_addr;
    assign port_addr[1] = rt_addr;

    genvar gi;
    generate
        for (gi = 0; gi < NREGS; gi++) begin : g_unpack
            assign regs_arr[gi] = regs_flat[gi*DATA_W +: DATA_W];
        end

        for (gi = 0; gi < 2; gi++) begin : g_port
`ifdef WR_BYPASS_EN
            // $zero never forwards: it is hardwired to 0 whatever is written.
            assign fwd[gi] = we && (wr_addr == port_addr[gi]) &&
                             (port_addr[gi] != '0);
`else
            assign fwd[gi] = 1'b0;
`endif

            always_comb begin
                operand[gi] = regs_arr[port_addr[gi]];
                if (port_addr[gi] == '0) begin
                    operand[gi] = '0;
                end else if (fwd[gi]) begin
                    operand[gi] = wr_data;
                end
            end
        end
    endgenerate

    // Handshake FSM. In RESP the block can take a new request only in the same
    // cycle that the consumer takes the current one, so back-to-back reads run
    // at one per cycle and a stalled consumer blocks new captures.
    always_comb begin
        state_next = state_reg;
        valid_next = valid_reg;
        rd_accept  = rd_req & ((state_reg == IDLE) | rd_ready);
        case (state_reg)
            IDLE: begin
                if (rd_accept) begin
                    state_next = RESP;
                    valid_next = 1'b1;
                end
            end
            RESP: begin
                if (rd_ready) begin
                    if (rd_accept) begin
                        state_next = RESP;
                        valid_next = 1'b1;
                    end else begin
                        state_next = IDLE;
                        valid_next = 1'b0;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            valid_reg   <= 1'b0;
            rs_data_reg <= '0;
            rt_data_reg <= '0;
        end else begin
            state_reg <= state_next;
            valid_reg <= valid_next;
            // Snapshot only on accept; later register writes do not leak in.
            if (rd_accept) begin
                rs_data_reg <= operand[0];
                rt_data_reg <= operand[1];
            end
        end
    end

`ifdef WR_BYPASS_EN
    logic [15:0] bypass_cnt_reg, bypass_cnt_next;
    logic [16:0] bypass_sum;

    assign bypass_sum      = {1'b0, bypass_cnt_reg} + 17'(fwd[0]) + 17'(fwd[1]);
    assign bypass_cnt_next = bypass_sum[16] ? 16'hFFFF : bypass_sum[15:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bypass_cnt_reg <= '0;
        end else if (rd_accept) begin
            bypass_cnt_reg <= bypass_cnt_next;
        end
    end

    assign bypass_cnt = bypass_cnt_reg;
`else
    // Write port is only needed for forwarding; sink it here.
    logic unused_wr;
    assign unused_wr  = &{1'b0, we, wr_addr, wr_data};
    assign bypass_cnt = '0;
`endif

    assign rd_valid = valid_reg;
    assign rs_data  = rs_data_reg;
    assign rt_data  = rt_data_reg;

endmodule

// File: tb/tb_reg_read_control.sv
module tb_reg_read_control;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [32*32-1:0]  regs_flat;
    logic              rd_req;
    logic [4:0]        rs_addr;
    logic [4:0]        rt_addr;
    logic              rd_ready;
    logic              we;
    logic [4:0]        wr_addr;
    logic [31:0]       wr_data;
    logic              rd_accept;
    logic              rd_valid;
    logic [31:0]       rs_data;
    logic [31:0]       rt_data;
    logic [15:0]       bypass_cnt;

    int checks = 0;
    int errors = 0;

    reg_read_control #(.DATA_W(32), .NREGS(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .regs_flat  (regs_flat),
        .rd_req     (rd_req),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rd_ready   (rd_ready),
        .we         (we),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .rd_accept  (rd_accept),
        .rd_valid   (rd_valid),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .bypass_cnt (bypass_cnt)
    );

    always #5 clk = ~clk;

    task automatic set_reg(input int k, input logic [31:0] v);
        regs_flat[k*32 +: 32] = v;
    endtask

    // Advance past the next rising edge and let registered outputs settle.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; regs_flat = '0; rd_req = 0; rs_addr = 0; rt_addr = 0;
        rd_ready = 0; we = 0; wr_addr = 0; wr_data = 0;
        #2;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", rd_valid); end
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL reset_rs got %h exp 0", rs_data); end
        checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL reset_rt got %h exp 0", rt_data); end
        checks++; if (bypass_cnt !== 16'h0) begin errors++; $display("FAIL reset_cnt got %h exp 0", bypass_cnt); end
        checks++; if (rd_accept !== 1'b0) begin errors++; $display("FAIL reset_accept got %b exp 0", rd_accept); end
        @(negedge clk);
        rst_n = 1'b1;
        $display("test_reset: outputs cleared");
    endtask

    task automatic test_basic_read();
        set_reg(5, 32'hA5A5_0001);
        set_reg(9, 32'h0000_1234);
        rd_req = 1; rs_addr = 5; rt_addr = 9; rd_ready = 1;
        #1;
        checks++; if (rd_accept !== 1'b1) begin errors++; $display("FAIL basic_accept got %b exp 1", rd_accept); end
        step();
        rd_req = 0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %b exp 1", rd_valid); end
        checks++; if (rs_data !== 32'hA5A5_0001) begin errors++; $display("FAIL basic_rs got %h exp a5a50001", rs_data); end
        checks++; if (rt_data !== 32'h0000_1234) begin errors++; $display("FAIL basic_rt got %h exp 00001234", rt_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL basic_valid_drop got %b exp 0", rd_valid); end
        $display("test_basic_read: rs=5 rt=9 -> %h %h", rs_data, rt_data);
    endtask

    task automatic test_zero();
        set_reg(0, 32'hFFFF_FFFF);
        we = 1; wr_addr = 0; wr_data = 32'h1357_9BDF;
        rd_req = 1; rs_addr = 0; rt_addr = 0; rd_ready = 1;
        step();
        rd_req = 0; we = 0;
        checks++; if (rs_data !== 32'h0) begin errors++; $display("FAIL zero_rs got %h exp 0", rs_data); end
        checks++; if (rt_data !== 32'h0) begin errors++; $display("FAIL zero_rt got %h exp 0", rt_data); end
        checks++; if (bypass_cnt !== 16'h0) begin errors++; $display("FAIL zero_cnt got %h exp 0", bypass_cnt); end
        step();
        $display("test_zero: rs=0 rt=0 -> %h %h cnt=%0d", rs_data, rt_data, bypass_cnt);
    endtask

    task automatic test_back_to_back();
        set_reg(3, 32'h0000_0033); set_reg(4, 32'h0000_0044);
        set_reg(7, 32'h0000_0077); set_reg(8, 32'h0000_0088);
        rd_req = 1; rs_addr = 3; rt_addr = 4; rd_ready = 1;
        step();
        rd_ready = 0; rs_addr = 7; rt_addr = 8;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (rd_accept !== 1'b0) begin errors++; $display("FAIL stall_accept[%0d] got %b exp 0", i, rd_accept); end
            step();
            checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d] got %b exp 1", i, rd_valid); end
            checks++; if ({rs_data, rt_data} !== {32'h33, 32'h44}) begin errors++; $display("FAIL stall_data[%0d] got %h %h exp 33 44", i, rs_data, rt_data); end
        end
        rd_ready = 1;
        #1;
        checks++; if (rd_accept !== 1'b1) begin errors++; $display("FAIL b2b_accept got %b exp 1", rd_accept); end
        step();
        rd_req = 0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b exp 1", rd_valid); end
        checks++; if ({rs_data, rt_data} !== {32'h77, 32'h88}) begin errors++; $display("FAIL b2b_data got %h %h exp 77 88", rs_data, rt_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop got %b exp 0", rd_valid); end
        $display("test_back_to_back: (3,4) held then (7,8) -> %h %h", rs_data, rt_data);
    endtask

    task automatic test_forward();
        logic [31:0] exp_rs, exp_rt;
        logic [15:0] exp_cnt;
        set_reg(10, 32'h0000_0001); set_reg(11, 32'h0000_0011); set_reg(12, 32'h0000_0012);
        we = 1; wr_addr = 10; wr_data = 32'hDEAD_BEEF;
        rd_req = 1; rs_addr = 10; rt_addr = 10; rd_ready = 1;
        step();
`ifdef WR_BYPASS_EN
        exp_rs = 32'hDEAD_BEEF; exp_cnt = 16'd2;
`else
        exp_rs = 32'h0000_0001; exp_cnt = 16'd0;
`endif
        checks++; if (rs_data !== exp_rs) begin errors++; $display("FAIL fwd_rs got %h exp %h", rs_data, exp_rs); end
        checks++; if (rt_data !== exp_rs) begin errors++; $display("FAIL fwd_rt got %h exp %h", rt_data, exp_rs); end
        checks++; if (bypass_cnt !== exp_cnt) begin errors++; $display("FAIL fwd_cnt got %0d exp %0d", bypass_cnt, exp_cnt); end
        // Back-to-back accept with only rt forwarded.
        wr_addr = 11; wr_data = 32'hCAFE_F00D; rs_addr = 12; rt_addr = 11;
        step();
        rd_req = 0; we = 0;
        exp_rs = 32'h0000_0012;
`ifdef WR_BYPASS_EN
        exp_rt = 32'hCAFE_F00D; exp_cnt = 16'd3;
`else
        exp_rt = 32'h0000_0011; exp_cnt = 16'd0;
`endif
        checks++; if (rs_data !== exp_rs) begin errors++; $display("FAIL fwd1_rs got %h exp %h", rs_data, exp_rs); end
        checks++; if (rt_data !== exp_rt) begin errors++; $display("FAIL fwd1_rt got %h exp %h", rt_data, exp_rt); end
        checks++; if (bypass_cnt !== exp_cnt) begin errors++; $display("FAIL fwd1_cnt got %0d exp %0d", bypass_cnt, exp_cnt); end
        step();
        $display("test_forward: rs=12 rt=11 -> %h %h cnt=%0d", rs_data, rt_data, bypass_cnt);
    endtask

    task automatic test_snapshot();
        set_reg(6, 32'h0000_0066);
        rd_req = 1; rs_addr = 6; rt_addr = 0; rd_ready = 1;
        step();
        rd_req = 0; rd_ready = 0;
        set_reg(6, 32'h0000_0077);
        we = 1; wr_addr = 6; wr_data = 32'h0000_0077; rs_addr = 6;
        step();
        step();
        checks++; if (rs_data !== 32'h0000_0066) begin errors++; $display("FAIL snap_rs got %h exp 66", rs_data); end
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL snap_valid got %b exp 1", rd_valid); end
        we = 0; rd_ready = 1;
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL snap_valid_drop got %b exp 0", rd_valid); end
        $display("test_snapshot: rs=6 held %h", rs_data);
    endtask

    task automatic test_async_reset();
        rd_req = 1; rs_addr = 5; rt_addr = 9; rd_ready = 1;
        step();
        rd_req = 0; rd_ready = 0;
        checks++; if (rd_valid !== 1'b1) begin errors++; $display("FAIL arst_pre_valid got %b exp 1", rd_valid); end
        #2;
        rst_n = 1'b0;
        #1;
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b exp 0", rd_valid); end
        checks++; if ({rs_data, rt_data} !== 64'h0) begin errors++; $display("FAIL arst_data got %h %h exp 0 0", rs_data, rt_data); end
        checks++; if (bypass_cnt !== 16'h0) begin errors++; $display("FAIL arst_cnt got %0d exp 0", bypass_cnt); end
        rst_n = 1'b1;
        rd_req = 1; rs_addr = 9; rt_addr = 5; rd_ready = 0;
        #1;
        checks++; if (rd_accept !== 1'b1) begin errors++; $display("FAIL arst_idle_accept got %b exp 1", rd_accept); end
        step();
        rd_req = 0; rd_ready = 1;
        checks++; if ({rs_data, rt_data} !== {32'h0000_1234, 32'hA5A5_0001}) begin errors++; $display("FAIL arst_after_data got %h %h exp 00001234 a5a50001", rs_data, rt_data); end
        step();
        checks++; if (rd_valid !== 1'b0) begin errors++; $display("FAIL arst_after_drop got %b exp 0", rd_valid); end
        $display("test_async_reset: post-reset read rs=9 rt=5 -> %h %h", rs_data, rt_data);
    endtask

`ifdef WR_BYPASS_EN
    task automatic test_saturation();
        // Counter is 0 here; each accept forwards both ports (+2).
        we = 1; wr_addr = 1; wr_data = 32'h5A5A_5A5A;
        rd_req = 1; rs_addr = 1; rt_addr = 1; rd_ready = 1;
        for (int i = 0; i < 32767; i++) step();
        checks++; if (bypass_cnt !== 16'hFFFE) begin errors++; $display("FAIL sat_pre got %h exp fffe", bypass_cnt); end
        step();
        checks++; if (bypass_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hit got %h exp ffff", bypass_cnt); end
        step();
        checks++; if (bypass_cnt !== 16'hFFFF) begin errors++; $display("FAIL sat_hold got %h exp ffff", bypass_cnt); end
        rd_req = 0; we = 0;
        step();
        $display("test_saturation: cnt=%h", bypass_cnt);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_read();
        test_zero();
        test_back_to_back();
        test_forward();
        test_snapshot();
        test_async_reset();
`ifdef WR_BYPASS_EN
        test_saturation();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
